// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and helpers for the multiplier-sharing controller.
// Holds the FSM state encoding, default operand width and round-robin pointer arithmetic.
package mult_share_ctrl_pkg;

   localparam int DEF_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Requester and multiplier signal bundle for mult_share_ctrl.
// slave = the controller, master = requesters plus the shared multiplier.
interface mult_share_ctrl_if
   import mult_share_ctrl_pkg::*;
#(
   parameter int W       = DEF_W,
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*W-1:0] req_a;
   logic [NUM_REQ*W-1:0] req_b;
   logic [NUM_REQ-1:0]   req_grant;
   logic [NUM_REQ-1:0]   resp_valid;
   logic [2*W:0]         resp_result;
   logic                 resp_err;
   logic                 busy;
   logic [W-1:0]         mult_a;
   logic [W-1:0]         mult_b;
   logic                 mult_start;
   logic                 mult_ready;
   logic [2*W:0]         mult_result;

   modport slave (
      input  req_valid, req_a, req_b, mult_ready, mult_result,
      output req_grant, resp_valid, resp_result, resp_err, busy, mult_a, mult_b, mult_start
   );

   modport master (
      output req_valid, req_a, req_b, mult_ready, mult_result,
      input  req_grant, resp_valid, resp_result, resp_err, busy, mult_a, mult_b, mult_start
   );
endinterface

// File: rtl/mult_share_ctrl_rr_priority_pick.sv
// Combinational round-robin pick: first set request bit at or above ptr_i, wrapping.
// Zero latency; any_o low means nothing to pick.
module rr_priority_pick
   import mult_share_ctrl_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
)(
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     pick_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);
   int               j;
   logic [IDX_W-1:0] jj;

   always_comb begin
      pick_o = '0;
      idx_o  = '0;
      any_o  = 1'b0;
      j      = 0;
      jj     = '0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr_i) + i;
         if (j >= N) j = j - N;
         jj = IDX_W'(j);
         if (!any_o && req_i[jj]) begin
            any_o      = 1'b1;
            pick_o[jj] = 1'b1;
            idx_o      = jj;
         end
      end
   end
endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin sharing of one multiplier among NUM_REQ requesters, one operation in flight.
// Grant 1 cycle after selection, response >=3 cycles after grant; requesters hold valid until granted.
module mult_share_ctrl
   import mult_share_ctrl_pkg::*;
#(
   parameter int W       = DEF_W,
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
)(
   input  logic             clk,
   input  logic             reset,
   mult_share_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PW    = 2 * W + 1;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   wd_q, wd_d;
   logic               first_q, first_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [PW-1:0]      res_q, res_d;
   logic               err_q, err_d;

   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic [NUM_REQ-1:0] owner_oh;

   rr_priority_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i  (bus.req_valid),
      .ptr_i  (ptr_q),
      .pick_o (pick_oh),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         wd_q    <= '0;
         first_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         wd_q    <= wd_d;
         first_q <= first_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      wd_d    = wd_q;
      first_d = first_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               owner_d = pick_idx;
               a_d     = bus.req_a[int'(pick_idx)*W +: W];
               b_d     = bus.req_b[int'(pick_idx)*W +: W];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            wd_d    = '0;
            first_d = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A ready left over from the previous operation is ignored in the first WAIT cycle.
            first_d = 1'b0;
            if (!first_q && bus.mult_ready) begin
               res_d   = bus.mult_result;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else begin
               wd_d = wd_q + CNT_W'(1);
               if (TIMEOUT != 0 && wd_d == CNT_W'(TIMEOUT)) begin
                  res_d   = '0;
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            ptr_d   = IDX_W'(rr_next(int'(owner_q), NUM_REQ));
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign owner_oh        = NUM_REQ'(1) << owner_q;
   assign bus.req_grant   = (state_q == ST_ISSUE) ? owner_oh : '0;
   assign bus.resp_valid  = (state_q == ST_RESP)  ? owner_oh : '0;
   assign bus.mult_start  = (state_q == ST_ISSUE);
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.mult_a      = a_q;
   assign bus.mult_b      = b_q;
   assign bus.resp_result = res_q;
   assign bus.resp_err    = err_q;
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with a latency-programmable multiplier model.
// The model can also present a stale ready during ISSUE and the first WAIT cycle.
module tb_mult_share_ctrl;
   localparam int W       = 64;
   localparam int NUM_REQ = 4;
   localparam int PW      = 2 * W + 1;

   logic clk;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_start = 0;
   int   n_resp  = 0;

   int   lat     = 2;
   bit   stale   = 1'b0;
   bit   active  = 1'b0;
   int   k       = 0;

   mult_share_ctrl_if #(.W(W), .NUM_REQ(NUM_REQ)) mif ();

   mult_share_ctrl #(
      .W       (W),
      .NUM_REQ (NUM_REQ),
      .TIMEOUT (8),
      .CNT_W   (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mif.mult_start)     n_start <= n_start + 1;
      if (|mif.resp_valid)    n_resp  <= n_resp + 1;
   end

   // Multiplier model: ready pulses lat cycles after the start cycle.
   always @(negedge clk) begin
      if (reset) begin
         active          = 1'b0;
         mif.mult_ready  = 1'b0;
         mif.mult_result = '0;
      end else begin
         if (mif.mult_start) begin
            active = 1'b1;
            k      = 0;
         end else if (active) begin
            k = k + 1;
         end
         mif.mult_ready  = 1'b0;
         mif.mult_result = 129'h1dead;
         if (active && stale && k <= 1) mif.mult_ready = 1'b1;
         if (active && k == lat) begin
            mif.mult_ready  = 1'b1;
            mif.mult_result = PW'(mif.mult_a) * PW'(mif.mult_b);
            active          = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_grant(output logic [NUM_REQ-1:0] g, output int at);
      g  = '0;
      at = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (|mif.req_grant) begin
            g  = mif.req_grant;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_resp(output logic [NUM_REQ-1:0] v, output logic [PW-1:0] r,
                            output logic e, output int at, input int bound);
      v  = '0;
      r  = '1;
      e  = 1'bx;
      at = -1;
      for (int n = 0; n < bound; n++) begin
         @(negedge clk);
         if (|mif.resp_valid) begin
            v  = mif.resp_valid;
            r  = mif.resp_result;
            e  = mif.resp_err;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      mif.req_a[i*W +: W] = a;
      mif.req_b[i*W +: W] = b;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"},  PW'(mif.req_grant),  '0);
      chk({tag, "_rvalid"}, PW'(mif.resp_valid), '0);
      chk({tag, "_result"}, mif.resp_result,     '0);
      chk({tag, "_err"},    PW'(mif.resp_err),   '0);
      chk({tag, "_busy"},   PW'(mif.busy),       '0);
      chk({tag, "_mult_a"}, PW'(mif.mult_a),     '0);
      chk({tag, "_mult_b"}, PW'(mif.mult_b),     '0);
      chk({tag, "_start"},  PW'(mif.mult_start), '0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [NUM_REQ-1:0] g, v;
      logic [PW-1:0]      r;
      logic               e;
      int                 tg, tr, prev_tr, s0, r0;
      int                 ord [4] = '{0, 2, 0, 2};
      logic [PW-1:0]      ores [4] = '{129'd15, 129'd63, 129'd15, 129'd63};
      logic [W-1:0]       ones;

      reset         = 1'b1;
      mif.req_valid = '0;
      mif.req_a     = '0;
      mif.req_b     = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;

      // Single request, minimum latency.
      @(negedge clk);
      set_req(0, 64'd17, 64'd27);
      mif.req_valid = 4'b0001;
      s0 = n_start;
      wait_grant(g, tg);
      chk("t1_grant", PW'(g), 129'd1);
      chk("t1_start", PW'(mif.mult_start), 129'd1);
      chk("t1_mult_a", PW'(mif.mult_a), 129'd17);
      mif.req_valid = '0;
      wait_resp(v, r, e, tr, 20);
      chk("t1_rvalid", PW'(v), 129'd1);
      chk("t1_result", r, 129'd459);
      chk("t1_err", PW'(e), 129'd0);
      chk("t1_latency", PW'(tr - tg), 129'd3);
      @(negedge clk);
      chk("t1_nstart", PW'(n_start - s0), 129'd1);

      // All four at once after reset: strict order 0..3 with one idle cycle between.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, W'(i + 1), 64'd10);
      mif.req_valid = 4'b1111;
      prev_tr = 0;
      for (int i = 0; i < 4; i++) begin
         wait_grant(g, tg);
         chk("t2_grant", PW'(g), PW'(4'(1) << i));
         if (i > 0) chk("t2_gap", PW'(tg - prev_tr), 129'd2);
         mif.req_valid[i] = 1'b0;
         wait_resp(v, r, e, tr, 20);
         chk("t2_rvalid", PW'(v), PW'(4'(1) << i));
         chk("t2_result", r, PW'(10 * (i + 1)));
         prev_tr = tr;
         if (i < 3) begin
            @(negedge clk);
            chk("t2_busy_gap", PW'(mif.busy), 129'd0);
         end
      end

      // req0 held continuously plus req2: must alternate.
      set_req(0, 64'd3, 64'd5);
      set_req(2, 64'd7, 64'd9);
      mif.req_valid = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         wait_grant(g, tg);
         chk("t3_grant", PW'(g), PW'(4'(1) << ord[i]));
         if (i == 3) mif.req_valid = '0;
         wait_resp(v, r, e, tr, 20);
         chk("t3_result", r, ores[i]);
      end

      // Hung multiplier: watchdog abort after 8 WAIT cycles, pointer still advances.
      lat = 1000;
      set_req(1, 64'd4, 64'd4);
      mif.req_valid = 4'b0010;
      wait_grant(g, tg);
      chk("t4_grant", PW'(g), 129'd2);
      mif.req_valid = '0;
      wait_resp(v, r, e, tr, 30);
      chk("t4_rvalid", PW'(v), 129'd2);
      chk("t4_err", PW'(e), 129'd1);
      chk("t4_result", r, 129'd0);
      chk("t4_latency", PW'(tr - tg), 129'd9);
      lat = 2;
      set_req(1, 64'd2, 64'd3);
      set_req(2, 64'd5, 64'd5);
      mif.req_valid = 4'b0110;
      wait_grant(g, tg);
      chk("t4_ptr_grant", PW'(g), 129'd4);
      mif.req_valid[2] = 1'b0;
      wait_resp(v, r, e, tr, 20);
      chk("t4_next_result", r, 129'd25);
      chk("t4_next_err", PW'(e), 129'd0);
      wait_grant(g, tg);
      chk("t4_grant1", PW'(g), 129'd2);
      mif.req_valid[1] = 1'b0;
      wait_resp(v, r, e, tr, 20);
      chk("t4_result1", r, 129'd6);

      // Reset in the middle of WAIT drops the operation silently.
      lat = 6;
      set_req(0, 64'd5, 64'd6);
      mif.req_valid = 4'b0001;
      wait_grant(g, tg);
      chk("t5_grant", PW'(g), 129'd1);
      mif.req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      chk("t5_busy_pre", PW'(mif.busy), 129'd1);
      r0 = n_resp;
      reset = 1'b1;
      #1;
      chk_all_zero("t5_async");
      repeat (8) @(negedge clk);
      chk("t5_no_resp", PW'(n_resp - r0), 129'd0);
      lat = 2;
      set_req(3, 64'd8, 64'd8);
      set_req(0, 64'd9, 64'd9);
      mif.req_valid = 4'b1001;
      reset = 1'b0;
      wait_grant(g, tg);
      chk("t5_grant0", PW'(g), 129'd1);
      mif.req_valid[0] = 1'b0;
      wait_resp(v, r, e, tr, 20);
      chk("t5_result0", r, 129'd81);
      wait_grant(g, tg);
      chk("t5_grant3", PW'(g), 129'd8);
      mif.req_valid[3] = 1'b0;
      wait_resp(v, r, e, tr, 20);
      chk("t5_result3", r, 129'd64);

      // Stale ready through ISSUE and first WAIT, true ready later.
      stale = 1'b1;
      lat   = 7;
      set_req(2, 64'd11, 64'd13);
      mif.req_valid = 4'b0100;
      wait_grant(g, tg);
      chk("t6_grant", PW'(g), 129'd4);
      mif.req_valid = '0;
      r0 = n_resp;
      wait_resp(v, r, e, tr, 20);
      chk("t6_rvalid", PW'(v), 129'd4);
      chk("t6_result", r, 129'd143);
      chk("t6_err", PW'(e), 129'd0);
      chk("t6_latency", PW'(tr - tg), 129'd8);
      repeat (10) @(negedge clk);
      chk("t6_single_resp", PW'(n_resp - r0), 129'd1);

      // Full-width product.
      stale = 1'b0;
      lat   = 2;
      ones  = '1;
      set_req(1, ones, ones);
      mif.req_valid = 4'b0010;
      wait_grant(g, tg);
      chk("t6_max_grant", PW'(g), 129'd2);
      mif.req_valid = '0;
      wait_resp(v, r, e, tr, 20);
      chk("t6_max_result", r, 129'h0_FFFFFFFFFFFFFFFE_0000000000000001);
      chk("t6_max_err", PW'(e), 129'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
